// File: rtl/wb_initiator_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_initiator_bridge_if
// Description : CPU request/response and Wishbone classic initiator signals
//               of wb_initiator_bridge. The master modport is the bridge's
//               view; the slave modport is the view of the CPU and the
//               peripheral bus around it.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_initiator_bridge_if;
    // CPU request / response
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [1:0]  req_size_i;
    logic        req_signed_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    // Wishbone classic
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_signed_i, req_wdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        output req_valid_i, req_we_i, req_addr_i, req_size_i, req_signed_i, req_wdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface
`default_nettype wire

// File: rtl/wb_initiator_bridge.sv
`default_nettype none
// ============================================================================
// Module      : wb_initiator_bridge
// Description : Single-outstanding Wishbone classic initiator. Converts one
//               CPU load/store into one Wishbone cycle with byte-lane
//               steering, load alignment/extension, misalignment and bus
//               error reporting. One response strobe per accepted request.
//               Optional bus timeout: define WB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_initiator_bridge #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    wb_initiator_bridge_if.master bus
);

    // Catch a meaningless timeout setting at elaboration time.
    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("wb_initiator_bridge: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q,     state_d;
    logic        cyc_q,       cyc_d;
    logic        we_q,        we_d;
    logic [31:0] adr_q,       adr_d;
    logic [31:0] dat_q,       dat_d;
    logic [3:0]  sel_q,       sel_d;
    logic [1:0]  addr_lo_q,   addr_lo_d;
    logic [1:0]  size_q,      size_d;
    logic        signed_q,    signed_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q,   rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // Byte enables for the addressed lanes of a naturally aligned access.
    function automatic logic [3:0] lane_sel(input logic [1:0] lo, input logic [1:0] sz);
        case (sz)
            2'b00:   lane_sel = 4'b0001 << lo;
            2'b01:   lane_sel = 4'b0011 << {lo[1], 1'b0};
            default: lane_sel = 4'b1111;
        endcase
    endfunction

    // Right-aligned store data replicated onto every lane it may land on.
    function automatic logic [31:0] lane_dat(input logic [31:0] wd, input logic [1:0] sz);
        case (sz)
            2'b00:   lane_dat = {4{wd[7:0]}};
            2'b01:   lane_dat = {2{wd[15:0]}};
            default: lane_dat = wd;
        endcase
    endfunction

    // Move the addressed lane down to bit 0 and zero/sign extend it.
    function automatic logic [31:0] load_align(input logic [31:0] d, input logic [1:0] lo,
                                               input logic [1:0] sz, input logic sgn);
        logic [31:0] sh;
        sh = d >> {lo, 3'b000};
        case (sz)
            2'b00:   load_align = {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   load_align = {{16{sgn & sh[15]}}, sh[15:0]};
            default: load_align = sh;
        endcase
    endfunction

    logic w_misaligned;
    assign w_misaligned = (bus.req_size_i == 2'b11)
                        || ((bus.req_size_i == 2'b01) && bus.req_addr_i[0])
                        || ((bus.req_size_i == 2'b10) && (bus.req_addr_i[1:0] != 2'b00));

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        addr_lo_d   = addr_lo_q;
        size_d      = size_q;
        signed_d    = signed_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef WB_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef WB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                if (bus.req_valid_i) begin
                    we_d      = bus.req_we_i;
                    adr_d     = {bus.req_addr_i[31:2], 2'b00};
                    addr_lo_d = bus.req_addr_i[1:0];
                    size_d    = bus.req_size_i;
                    signed_d  = bus.req_signed_i;
                    sel_d     = lane_sel(bus.req_addr_i[1:0], bus.req_size_i);
                    dat_d     = lane_dat(bus.req_wdata_i, bus.req_size_i);
                    if (w_misaligned) begin
                        // Rejected locally: answer directly, never touch the bus.
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = ST_BUS;
                        cyc_d   = 1'b1;
                    end
                end
            end
            ST_BUS: begin
                if (bus.wb_err_i) begin
                    // Error has priority over a simultaneous ack.
                    state_d     = ST_RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else if (bus.wb_ack_i) begin
                    state_d     = ST_RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = we_q ? 32'd0
                                       : load_align(bus.wb_dat_i, addr_lo_q, size_q, signed_q);
                end
`ifdef WB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    // Slave never answered: abandon the cycle with an error.
                    state_d     = ST_RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            addr_lo_q   <= '0;
            size_q      <= '0;
            signed_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef WB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            addr_lo_q   <= addr_lo_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef WB_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign bus.req_ready_o = (state_q == ST_IDLE);
    assign bus.wb_cyc_o    = cyc_q;
    assign bus.wb_stb_o    = cyc_q;
    assign bus.wb_we_o     = we_q;
    assign bus.wb_adr_o    = adr_q;
    assign bus.wb_dat_o    = dat_q;
    assign bus.wb_sel_o    = sel_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;

endmodule
`default_nettype wire
